// File: rtl/ex_stage_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ex_stage_pipe : pentaRV execute stage (forwarding, ALU, branch, EX/MEM).  |
// | Optional iterative multiplier enabled by macro EX_STAGE_MUL_EN. Rev 1.0    |
// +--------------------------------------------------------------------------+
module ex_stage_pipe #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      op,
   input  logic [1:0]      src_a_sel,
   input  logic            src_b_sel,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] r1,
   input  logic [XLEN-1:0] r2,
   input  logic [RA_W-1:0] rs1,
   input  logic [RA_W-1:0] rs2,
   input  logic [RA_W-1:0] rd,
   input  logic            reg_write,
   input  logic            mem_write,
   input  logic            mem_to_reg,
   input  logic [2:0]      str_ctrl,
   input  logic            branch_en,
   input  logic [2:0]      br_funct,
   input  logic            mem_fwd_we,
   input  logic [RA_W-1:0] mem_fwd_rd,
   input  logic [XLEN-1:0] mem_fwd_data,
   input  logic            wb_fwd_we,
   input  logic [RA_W-1:0] wb_fwd_rd,
   input  logic [XLEN-1:0] wb_fwd_data,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_out_m,
   output logic [XLEN-1:0] pc_imm_m,
   output logic [XLEN-1:0] r2_m,
   output logic [RA_W-1:0] rd_m,
   output logic            reg_write_m,
   output logic            mem_write_m,
   output logic            mem_to_reg_m,
   output logic [2:0]      str_ctrl_m,
   output logic            branch_taken_m,
   output logic            busy
);
   localparam int SH_W = $clog2(XLEN);
   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_SLT  = 4'b1000;
   localparam logic [3:0] OP_SLTU = 4'b1001;

   logic [XLEN-1:0] r1_fwd, r2_fwd, op_a, op_b, alu_d, pc_imm_d;
   logic            cmp_true, br_taken_d;
   logic            idle, out_free, accept, is_mul, ld_plain;

   logic            out_valid_q, reg_write_q, mem_write_q, mem_to_reg_q, br_taken_q;
   logic [XLEN-1:0] alu_out_q, pc_imm_q, r2_q;
   logic [RA_W-1:0] rd_q;
   logic [2:0]      str_ctrl_q;

   // MEM stage is the younger producer, so it wins over WB; x0 is never forwarded.
   assign r1_fwd = (mem_fwd_we && mem_fwd_rd == rs1 && rs1 != '0) ? mem_fwd_data :
                   (wb_fwd_we  && wb_fwd_rd  == rs1 && rs1 != '0) ? wb_fwd_data  : r1;
   assign r2_fwd = (mem_fwd_we && mem_fwd_rd == rs2 && rs2 != '0) ? mem_fwd_data :
                   (wb_fwd_we  && wb_fwd_rd  == rs2 && rs2 != '0) ? wb_fwd_data  : r2;

   always_comb begin
      op_a = '0;
      if (src_a_sel == 2'b00)      op_a = pc;
      else if (src_a_sel == 2'b11) op_a = r1_fwd;
      op_b = src_b_sel ? imm : r2_fwd;
   end

   always_comb begin
      alu_d = '0;
      case (op)
         OP_ADD:  alu_d = op_a + op_b;
         OP_SUB:  alu_d = op_a - op_b;
         OP_AND:  alu_d = op_a & op_b;
         OP_OR:   alu_d = op_a | op_b;
         OP_XOR:  alu_d = op_a ^ op_b;
         OP_SLL:  alu_d = op_a << op_b[SH_W-1:0];
         OP_SRL:  alu_d = op_a >> op_b[SH_W-1:0];
         OP_SRA:  alu_d = $signed(op_a) >>> op_b[SH_W-1:0];
         OP_SLT:  alu_d = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         OP_SLTU: alu_d = {{(XLEN-1){1'b0}}, op_a < op_b};
         default: alu_d = '0;
      endcase
   end

   always_comb begin
      cmp_true = 1'b0;
      case (br_funct)
         3'b000:  cmp_true = (r1_fwd == r2_fwd);
         3'b001:  cmp_true = (r1_fwd != r2_fwd);
         3'b100:  cmp_true = ($signed(r1_fwd) <  $signed(r2_fwd));
         3'b101:  cmp_true = ($signed(r1_fwd) >= $signed(r2_fwd));
         3'b110:  cmp_true = (r1_fwd <  r2_fwd);
         3'b111:  cmp_true = (r1_fwd >= r2_fwd);
         default: cmp_true = 1'b0;
      endcase
   end

   assign br_taken_d = branch_en && cmp_true;
   assign pc_imm_d   = pc + imm;
   assign out_free   = !out_valid_q || out_ready;
   assign in_ready   = idle && out_free;
   assign accept     = in_valid && in_ready && !flush;
   assign ld_plain   = accept && !is_mul;

`ifdef EX_STAGE_MUL_EN
   localparam logic [3:0] OP_MUL = 4'b1010;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_MDONE = 2'd2} state_t;

   state_t          state_q;
   logic [XLEN-1:0] mcand_q, mplier_q, prod_q, h_pc_imm_q, h_r2_q;
   logic [SH_W-1:0] cnt_q;
   logic [RA_W-1:0] h_rd_q;
   logic [2:0]      h_str_q;
   logic            h_rw_q, h_mw_q, h_m2r_q, h_br_q;
   logic            ld_mul;

   assign is_mul = (op == OP_MUL);
   assign idle   = (state_q == S_IDLE);
   assign busy   = !idle;
   assign ld_mul = (state_q == S_MDONE) && out_free && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         mcand_q    <= '0;
         mplier_q   <= '0;
         prod_q     <= '0;
         cnt_q      <= '0;
         h_pc_imm_q <= '0;
         h_r2_q     <= '0;
         h_rd_q     <= '0;
         h_str_q    <= '0;
         h_rw_q     <= 1'b0;
         h_mw_q     <= 1'b0;
         h_m2r_q    <= 1'b0;
         h_br_q     <= 1'b0;
      end else if (flush) begin
         state_q <= S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (accept && is_mul) begin
               mcand_q    <= op_a;
               mplier_q   <= op_b;
               prod_q     <= '0;
               cnt_q      <= '0;
               h_pc_imm_q <= pc_imm_d;
               h_r2_q     <= r2_fwd;
               h_rd_q     <= rd;
               h_str_q    <= str_ctrl;
               h_rw_q     <= reg_write;
               h_mw_q     <= mem_write;
               h_m2r_q    <= mem_to_reg;
               h_br_q     <= br_taken_d;
               state_q    <= S_MUL;
            end
            S_MUL: begin
               // One multiplier bit per cycle; overflow past XLEN is discarded.
               if (mplier_q[0]) prod_q <= prod_q + mcand_q;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 1'b1;
               if (cnt_q == SH_W'(XLEN - 1)) state_q <= S_MDONE;
            end
            S_MDONE: if (out_free) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end
`else
   assign is_mul = 1'b0;
   assign idle   = 1'b1;
   assign busy   = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         alu_out_q    <= '0;
         pc_imm_q     <= '0;
         r2_q         <= '0;
         rd_q         <= '0;
         reg_write_q  <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         str_ctrl_q   <= '0;
         br_taken_q   <= 1'b0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
      end else if (ld_plain) begin
         out_valid_q  <= 1'b1;
         alu_out_q    <= alu_d;
         pc_imm_q     <= pc_imm_d;
         r2_q         <= r2_fwd;
         rd_q         <= rd;
         reg_write_q  <= reg_write;
         mem_write_q  <= mem_write;
         mem_to_reg_q <= mem_to_reg;
         str_ctrl_q   <= str_ctrl;
         br_taken_q   <= br_taken_d;
`ifdef EX_STAGE_MUL_EN
      end else if (ld_mul) begin
         out_valid_q  <= 1'b1;
         alu_out_q    <= prod_q;
         pc_imm_q     <= h_pc_imm_q;
         r2_q         <= h_r2_q;
         rd_q         <= h_rd_q;
         reg_write_q  <= h_rw_q;
         mem_write_q  <= h_mw_q;
         mem_to_reg_q <= h_m2r_q;
         str_ctrl_q   <= h_str_q;
         br_taken_q   <= h_br_q;
`endif
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid      = out_valid_q;
   assign alu_out_m      = alu_out_q;
   assign pc_imm_m       = pc_imm_q;
   assign r2_m           = r2_q;
   assign rd_m           = rd_q;
   assign reg_write_m    = reg_write_q;
   assign mem_write_m    = mem_write_q;
   assign mem_to_reg_m   = mem_to_reg_q;
   assign str_ctrl_m     = str_ctrl_q;
   assign branch_taken_m = br_taken_q;
endmodule
`default_nettype wire

// File: tb/tb_ex_stage_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ex_stage_pipe : directed + randomized bench for ex_stage_pipe.          |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module tb_ex_stage_pipe;
   localparam int XLEN = 32;
   localparam int RA_W = 5;
`ifdef EX_STAGE_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif
   localparam logic [XLEN-1:0] ZERO = '0;
   localparam logic [XLEN-1:0] ONE  = 1;
   localparam logic [XLEN-1:0] ONES = '1;
   localparam logic [XLEN-1:0] SIGN = {1'b1, {(XLEN-1){1'b0}}};

   logic            clk = 1'b0;
   logic            rst, in_valid, in_ready, src_b_sel, reg_write, mem_write, mem_to_reg;
   logic [3:0]      op;
   logic [1:0]      src_a_sel;
   logic [XLEN-1:0] imm, pc, r1, r2, mem_fwd_data, wb_fwd_data;
   logic [RA_W-1:0] rs1, rs2, rd, mem_fwd_rd, wb_fwd_rd, rd_m;
   logic [2:0]      str_ctrl, br_funct, str_ctrl_m;
   logic            branch_en, mem_fwd_we, wb_fwd_we, flush, out_valid, out_ready;
   logic [XLEN-1:0] alu_out_m, pc_imm_m, r2_m;
   logic            reg_write_m, mem_write_m, mem_to_reg_m, branch_taken_m, busy;

   int total = 0;
   int bad   = 0;

   logic [XLEN-1:0] e_alu, e_pcimm, e_r2;
   logic [RA_W-1:0] e_rd;
   logic [2:0]      e_str;
   logic            e_rw, e_mw, e_m2r, e_br;
   bit              e_mul;

   ex_stage_pipe #(.XLEN(XLEN), .RA_W(RA_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .src_a_sel(src_a_sel), .src_b_sel(src_b_sel), .imm(imm), .pc(pc), .r1(r1), .r2(r2),
      .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write), .mem_write(mem_write),
      .mem_to_reg(mem_to_reg), .str_ctrl(str_ctrl), .branch_en(branch_en), .br_funct(br_funct),
      .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
      .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .alu_out_m(alu_out_m),
      .pc_imm_m(pc_imm_m), .r2_m(r2_m), .rd_m(rd_m), .reg_write_m(reg_write_m),
      .mem_write_m(mem_write_m), .mem_to_reg_m(mem_to_reg_m), .str_ctrl_m(str_ctrl_m),
      .branch_taken_m(branch_taken_m), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [XLEN-1:0] fwd(input logic [RA_W-1:0] rs, input logic [XLEN-1:0] pv);
      if (rs == '0) return pv;
      if (mem_fwd_we && mem_fwd_rd == rs) return mem_fwd_data;
      if (wb_fwd_we && wb_fwd_rd == rs) return wb_fwd_data;
      return pv;
   endfunction

   function automatic logic [XLEN-1:0] alu_ref(input logic [3:0] o, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
      int sh;
      sh = int'(b % XLEN);
      case (o)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return a << sh;
         4'd6:    return a >> sh;
         4'd7:    return (a >> sh) | (a[XLEN-1] ? ~(ONES >> sh) : ZERO);
         4'd8:    return ((a ^ SIGN) < (b ^ SIGN)) ? ONE : ZERO;
         4'd9:    return (a < b) ? ONE : ZERO;
         4'd10:   return MUL_EN ? a * b : ZERO;
         default: return ZERO;
      endcase
   endfunction

   function automatic logic br_ref(input logic [2:0] f, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
      case (f)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return (a ^ SIGN) <  (b ^ SIGN);
         3'd5:    return (a ^ SIGN) >= (b ^ SIGN);
         3'd6:    return a <  b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model();
      logic [XLEN-1:0] r1f, r2f, a, b;
      r1f = fwd(rs1, r1);
      r2f = fwd(rs2, r2);
      a = (src_a_sel == 2'b00) ? pc : (src_a_sel == 2'b11) ? r1f : ZERO;
      b = src_b_sel ? imm : r2f;
      e_alu   = alu_ref(op, a, b);
      e_pcimm = pc + imm;
      e_r2    = r2f;
      e_rd    = rd;
      e_rw    = reg_write;
      e_mw    = mem_write;
      e_m2r   = mem_to_reg;
      e_str   = str_ctrl;
      e_br    = branch_en && br_ref(br_funct, r1f, r2f);
      e_mul   = MUL_EN && (op == 4'b1010);
   endtask

   function automatic logic [XLEN-1:0] rv();
      case ($urandom_range(0, 4))
         0:       return ZERO;
         1:       return ONES;
         2:       return SIGN;
         default: return XLEN'($urandom);
      endcase
   endfunction

   task automatic scramble();
      op = 4'($urandom_range(0, 12));
      src_a_sel = 2'($urandom); src_b_sel = 1'($urandom);
      imm = rv(); pc = rv(); r1 = rv(); r2 = rv();
      rs1 = RA_W'($urandom_range(0, 3)); rs2 = RA_W'($urandom_range(0, 3));
      rd = RA_W'($urandom);
      reg_write = 1'($urandom); mem_write = 1'($urandom); mem_to_reg = 1'($urandom);
      str_ctrl = 3'($urandom); branch_en = 1'($urandom); br_funct = 3'($urandom);
      mem_fwd_we = 1'($urandom); mem_fwd_rd = RA_W'($urandom_range(0, 3)); mem_fwd_data = rv();
      wb_fwd_we = 1'($urandom); wb_fwd_rd = RA_W'($urandom_range(0, 3)); wb_fwd_data = rv();
   endtask

   task automatic clear_in();
      in_valid = 0; op = 0; src_a_sel = 2'b11; src_b_sel = 0; imm = 0; pc = 0; r1 = 0; r2 = 0;
      rs1 = 0; rs2 = 0; rd = 0; reg_write = 0; mem_write = 0; mem_to_reg = 0; str_ctrl = 0;
      branch_en = 0; br_funct = 0; mem_fwd_we = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
      wb_fwd_we = 0; wb_fwd_rd = 0; wb_fwd_data = 0; flush = 0; out_ready = 0;
   endtask

   task automatic chk_outputs(input string tag);
      chk({tag, ".alu"}, alu_out_m, e_alu);
      chk({tag, ".pcimm"}, pc_imm_m, e_pcimm);
      chk({tag, ".r2"}, r2_m, e_r2);
      chk({tag, ".ctl"}, {rd_m, reg_write_m, mem_write_m, mem_to_reg_m, str_ctrl_m},
          {e_rd, e_rw, e_mw, e_m2r, e_str});
      chk({tag, ".br"}, branch_taken_m, e_br);
   endtask

   // Issues the currently driven instruction, waits for it, checks it, holds, then drains.
   task automatic run_instr(input string tag, input int stall);
      int lat;
      bit busy_all, rdy_seen, stable;
      model();
      in_valid = 1; out_ready = 0;
      #1;
      chk({tag, ".in_ready"}, in_ready, 1);
      step();
      in_valid = 0;
      scramble();
      chk({tag, ".busy_acc"}, busy, e_mul);
      chk({tag, ".in_ready_acc"}, in_ready, 0);
      lat = 1; busy_all = 1; rdy_seen = 0;
      while (!out_valid && lat < XLEN + 10) begin
         busy_all &= busy;
         rdy_seen |= in_ready;
         step();
         lat++;
      end
      chk({tag, ".busy_held"}, busy_all, 1);
      chk({tag, ".no_ready_mul"}, rdy_seen, 0);
      chk({tag, ".latency"}, e_mul ? (lat >= XLEN + 1 && lat <= XLEN + 4) : (lat == 1), 1);
      chk({tag, ".out_valid"}, out_valid, 1);
      chk({tag, ".busy_done"}, busy, 0);
      chk_outputs(tag);
      stable = 1;
      repeat (stall) begin
         scramble();
         in_valid = 1;
         step();
         stable &= (out_valid === 1'b1) && (alu_out_m === e_alu) && (pc_imm_m === e_pcimm) &&
                   (r2_m === e_r2) && (rd_m === e_rd) && (str_ctrl_m === e_str) &&
                   (branch_taken_m === e_br) && (in_ready === 1'b0);
      end
      chk({tag, ".hold"}, stable, 1);
      in_valid = 0; out_ready = 1;
      step();
      chk({tag, ".drain"}, out_valid, 0);
      out_ready = 0;
   endtask

   initial begin
      bit no_out;
      clear_in();
      rst = 1;
      repeat (2) step();
      chk("rst.out_valid", out_valid, 0);
      chk("rst.busy", busy, 0);
      chk("rst.alu", alu_out_m, 0);
      chk("rst.ctl", {pc_imm_m, r2_m, rd_m, reg_write_m, mem_write_m, mem_to_reg_m,
                      str_ctrl_m, branch_taken_m}, 0);
      rst = 0;
      #1;
      chk("rst.in_ready", in_ready, 1);

      // Plain ADD
      clear_in(); op = 4'd0; r1 = 5; r2 = 7; rs1 = 1; rs2 = 2; rd = 4; reg_write = 1;
      run_instr("add", 0);

      // Forwarding: MEM beats WB, x0 never forwarded, WB alone
      clear_in(); op = 4'd0; rs1 = 3; r1 = 55; imm = 1; src_b_sel = 1;
      mem_fwd_we = 1; mem_fwd_rd = 3; mem_fwd_data = 100;
      wb_fwd_we = 1; wb_fwd_rd = 3; wb_fwd_data = 200;
      run_instr("fwd_mem", 1);
      clear_in(); op = 4'd0; rs1 = 0; r1 = 40; imm = 1; src_b_sel = 1;
      mem_fwd_we = 1; mem_fwd_rd = 0; mem_fwd_data = 100;
      wb_fwd_we = 1; wb_fwd_rd = 0; wb_fwd_data = 200;
      run_instr("fwd_x0", 0);
      clear_in(); op = 4'd0; rs1 = 3; r1 = 40; imm = 1; src_b_sel = 1;
      wb_fwd_we = 1; wb_fwd_rd = 3; wb_fwd_data = 200;
      run_instr("fwd_wb", 0);

      // Backpressure: second instruction waits until out_ready returns
      clear_in(); op = 4'd0; r1 = 10; r2 = 20; rd = 1;
      model();
      in_valid = 1;
      #1;
      step();
      chk("bp.first", alu_out_m, e_alu);
      op = 4'd1; r1 = 100; r2 = 1; rd = 2;
      model();
      repeat (3) begin
         step();
         chk("bp.in_ready", in_ready, 0);
         chk("bp.frozen", alu_out_m, 32'd30);
      end
      out_ready = 1;
      #1;
      chk("bp.in_ready_rel", in_ready, 1);
      step();
      in_valid = 0; out_ready = 0;
      chk("bp.second_valid", out_valid, 1);
      chk_outputs("bp.second");
      out_ready = 1;
      step();
      out_ready = 0;

      // Multiply with wraparound
      clear_in(); op = 4'd10; r1 = ONES; r2 = 3; rs1 = 1; rs2 = 2; pc = 8; imm = 4; rd = 9;
      run_instr("mul", 1);

      // Flush of a held output while a new instruction is offered
      clear_in(); op = 4'd0; r1 = 1; r2 = 2;
      in_valid = 1;
      #1;
      step();
      flush = 1; out_ready = 1; op = 4'd2; r1 = ONES; r2 = ONES;
      step();
      flush = 0; in_valid = 0; out_ready = 0;
      #1;
      chk("flush.out_valid", out_valid, 0);
      chk("flush.in_ready", in_ready, 1);

      // Flush mid-multiply, then an ADD accepted right after
      clear_in(); op = 4'd10; r1 = 123; r2 = 456;
      in_valid = 1;
      #1;
      step();
      in_valid = 0;
      repeat (10) step();
      flush = 1;
      step();
      flush = 0;
      chk("flush_mul.busy", busy, 0);
      chk("flush_mul.out_valid", out_valid, 0);
      clear_in(); op = 4'd0; r1 = 3; r2 = 4;
      run_instr("post_flush_add", 0);

      // Signed vs unsigned branch on the same operands
      clear_in(); branch_en = 1; br_funct = 3'b100; r1 = ONES; r2 = 1; rs1 = 1; rs2 = 2;
      run_instr("blt", 0);
      clear_in(); branch_en = 1; br_funct = 3'b110; r1 = ONES; r2 = 1; rs1 = 1; rs2 = 2;
      run_instr("bltu", 0);

      for (int i = 0; i < 40; i++) begin
         clear_in();
         scramble();
         run_instr($sformatf("rnd%0d", i), int'($urandom_range(0, 2)));
      end

      // Asynchronous reset clears a held output without a clock edge
      clear_in(); op = 4'd0; r1 = 9; r2 = 9;
      in_valid = 1;
      #1;
      step();
      in_valid = 0;
      #2 rst = 1;
      #1;
      chk("async_rst.out_valid", out_valid, 0);
      chk("async_rst.alu", alu_out_m, 0);
      step();
      rst = 0;

      // Reset mid-multiply produces no output
      clear_in(); op = 4'd10; r1 = 7; r2 = 7;
      in_valid = 1;
      #1;
      step();
      in_valid = 0; out_ready = 1;
      repeat (4) step();
      #2 rst = 1;
      #1;
      chk("rst_mul.busy", busy, 0);
      step();
      rst = 0;
      no_out = 1;
      repeat (XLEN + 4) begin
         step();
         no_out &= !out_valid;
      end
      chk("rst_mul.no_output", no_out, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
